// File: rtl/fifo_pkg.sv
// fifo_pkg: shared state encoding and default word width for the FIFO read adapter
package fifo_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [2:0] {
        S_EMPTY = 3'b001,
        S_ONE   = 3'b010,
        S_TWO   = 3'b100
    } state_t;

endpackage

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: synchronous_fifo flag/head interface to valid/ready stream via 2-entry skid buffer
// Optional accepted-word counter enabled by defining FIFO_READER_COUNT_EN.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             fifo_is_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_dequeue_request,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [15:0]      out_count
);

    state_t           r_state;
    logic             r_valid;
    logic             r_deq;
    logic [WIDTH-1:0] r_h;
    logic [WIDTH-1:0] r_t;
    logic             w_capture;
    logic             w_drain;

    assign w_capture            = r_deq & ~fifo_is_empty;
    assign w_drain              = r_valid & out_ready;
    assign fifo_dequeue_request = r_deq;
    assign out_valid            = r_valid;
    assign out_data             = r_h;

    // skid-buffer FSM; valid/dequeue are registered alongside the next state
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= S_EMPTY;
            r_valid <= 1'b0;
            r_deq   <= 1'b1;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_capture) begin
                        r_h     <= fifo_data;
                        r_state <= S_ONE;
                        r_valid <= 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_capture && w_drain) begin
                        r_h <= fifo_data;
                    end else if (w_capture) begin
                        r_t     <= fifo_data;
                        r_state <= S_TWO;
                        r_deq   <= 1'b0;
                    end else if (w_drain) begin
                        r_state <= S_EMPTY;
                        r_valid <= 1'b0;
                    end
                end
                S_TWO: begin
                    if (w_drain) begin
                        r_h     <= r_t;
                        r_state <= S_ONE;
                        r_deq   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_EMPTY;
                    r_valid <= 1'b0;
                    r_deq   <= 1'b1;
                end
            endcase
        end
    end

`ifdef FIFO_READER_COUNT_EN
    logic [15:0] r_count;

    assign out_count = r_count;

    // saturating count of words accepted downstream
    always_ff @(posedge CLK) begin
        if (reset) r_count <= '0;
        else if (w_drain && r_count != 16'hFFFF) r_count <= r_count + 16'd1;
    end
`else
    assign out_count = '0;
`endif

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 CLK  input  1  clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high; clock CLK.
REQ-004 fifo_is_empty  input  1  registered empty flag from synchronous_fifo.
REQ-005 fifo_data  input  WIDTH  synchronous_fifo head word, valid whenever fifo_is_empty=0.
REQ-006 fifo_dequeue_request  output  1  dequeue strobe to synchronous_fifo.
REQ-007 out_valid  output  1  out_data holds a word.
REQ-008 out_ready  input  1  downstream accepts the word this cycle.
REQ-009 out_data  output  WIDTH  current output word.
REQ-010 out_count  output  16  accepted-word counter (see Configuration).

Function
REQ-011 Block SHALL be the read-side adapter of synchronous_fifo: FIFO flag/head interface in, valid/ready stream out, through a 2-entry skid buffer (head H, tail T).
REQ-012 State machine SHALL have states S_EMPTY (0 words), S_ONE (H valid), S_TWO (H and T valid); one-hot encoding.
REQ-013 fifo_dequeue_request SHALL equal (state != S_TWO), decoded from registered state only; no combinational path from out_ready or fifo_is_empty.
REQ-014 Capture SHALL occur at an edge when fifo_dequeue_request=1 and fifo_is_empty=0; the captured word is fifo_data sampled at that edge (zero-latency head).
REQ-015 Drain SHALL occur at an edge when out_valid=1 and out_ready=1.
REQ-016 out_valid SHALL equal (state != S_EMPTY); out_data SHALL be H, registered.
REQ-017 S_EMPTY: capture -> H<=word, S_ONE; else stay.
REQ-018 S_ONE: capture and drain -> H<=word, stay; capture only -> T<=word, S_TWO; drain only -> S_EMPTY; neither -> stay.
REQ-019 S_TWO: drain -> H<=T, S_ONE (no capture possible); else stay, H and T hold.
REQ-020 Word order at out_data SHALL equal FIFO dequeue order; no word SHALL be lost or duplicated.
REQ-021 Sustained throughput SHALL be 1 word/cycle when FIFO non-empty and out_ready=1 continuously.
REQ-022 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 fifo_data SHALL be ignored when fifo_is_empty=1.

Reset
REQ-024 On reset=1: state<=S_EMPTY, out_valid=0, fifo_dequeue_request=1, out_count=0; H and T unchanged, don't-care.
REQ-025 Reset mid-operation SHALL discard buffered words; no capture or drain counted in the reset cycle.

Configuration
REQ-026 With FIFO_READER_COUNT_EN defined: out_count SHALL increment by 1 per drain and saturate at 16'hFFFF.
REQ-027 Without FIFO_READER_COUNT_EN: out_count SHALL be tied to 0, no counter flops; the port remains present.

Structure
REQ-028 Shared package fifo_pkg SHALL hold the state typedef (S_EMPTY/S_ONE/S_TWO) and the default WIDTH constant.
REQ-029 Block SHALL be a single module; no sub-module; instantiated beside synchronous_fifo, replacing direct consumer connection.

Verification
REQ-030 Reset, FIFO empty -> out_valid=0, fifo_dequeue_request=1, out_count=0.
REQ-031 Enqueue 8'h00..8'h03, out_ready=1 constant -> out_data 00,01,02,03 on consecutive cycles, first word one cycle after FIFO becomes non-empty.
REQ-032 FIFO holds 8'h10,8'h11,8'h12, out_ready=0 -> state S_TWO, fifo_dequeue_request=0, out_data=8'h10 stable, 8'h12 remains in FIFO; raise out_ready -> 10,11,12 in order.
REQ-033 Random out_ready (50%) over 256 words 00..FF -> exact in-order sequence, no drops or duplicates.
REQ-034 Reset asserted in S_TWO -> next cycle out_valid=0, out_count=0.
REQ-035 FIFO_READER_COUNT_EN defined, 70000 words drained -> out_count=16'hFFFF; undefined -> out_count=0 throughout.
